// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus multi-cycle shift-add multiply.
// Define SEQ_ALU_DIV_EN to build the restoring divider for divu/remu; otherwise those opcodes are illegal.
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALU_Operation,
    input  logic [XLEN-1:0] oprd1,
    input  logic [XLEN-1:0] oprd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [SHW-1:0]  cnt_reg, cnt_next;
    logic [3:0]      op_reg, op_next;
    logic [XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0] mq_reg, mq_next;
    logic [XLEN-1:0] b_reg, b_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            illegal_reg, illegal_next;
    logic            has_result_reg, has_result_next;

    logic [XLEN-1:0] ss_res;
    logic            ss_legal;
    logic            is_multi;
    logic [SHW-1:0]  shamt;

    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] step_acc, step_mq, calc_res;
`ifdef SEQ_ALU_DIV_EN
    logic [XLEN:0]   div_shift, div_trial;
`endif

    assign shamt = oprd2[SHW-1:0];

    always_comb begin
        ss_res   = '0;
        ss_legal = 1'b1;
        is_multi = 1'b0;
        case (ALU_Operation)
            OP_AND:  ss_res = oprd1 & oprd2;
            OP_OR:   ss_res = oprd1 | oprd2;
            OP_NOR:  ss_res = ~(oprd1 | oprd2);
            OP_XOR:  ss_res = oprd1 ^ oprd2;
            OP_ADD:  ss_res = oprd1 + oprd2;
            OP_SUB:  ss_res = oprd1 - oprd2;
            OP_SLT:  ss_res = {{(XLEN-1){1'b0}}, $signed(oprd1) < $signed(oprd2)};
            OP_SLTU: ss_res = {{(XLEN-1){1'b0}}, oprd1 < oprd2};
            OP_SLL:  ss_res = oprd1 << shamt;
            OP_SRL:  ss_res = oprd1 >> shamt;
            OP_SRA:  ss_res = $unsigned($signed(oprd1) >>> shamt);
            OP_MUL, OP_MULHU: is_multi = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU, OP_REMU: is_multi = 1'b1;
`else
            OP_DIVU, OP_REMU: ss_legal = 1'b0;
`endif
            default: ss_legal = 1'b0;
        endcase
    end

    // acc holds the running high half (multiply) or partial remainder (divide);
    // mq shifts out multiplier bits or shifts in quotient bits.
    always_comb begin
        mul_sum  = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, b_reg} : '0);
        step_acc = mul_sum[XLEN:1];
        step_mq  = {mul_sum[0], mq_reg[XLEN-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_shift = {acc_reg, mq_reg[XLEN-1]};
        div_trial = div_shift - {1'b0, b_reg};
        if (op_reg == OP_DIVU || op_reg == OP_REMU) begin
            if (!div_trial[XLEN]) begin
                step_acc = div_trial[XLEN-1:0];
                step_mq  = {mq_reg[XLEN-2:0], 1'b1};
            end else begin
                step_acc = div_shift[XLEN-1:0];
                step_mq  = {mq_reg[XLEN-2:0], 1'b0};
            end
        end
`endif
        calc_res = (op_reg == OP_MUL || op_reg == OP_DIVU) ? step_mq : step_acc;
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        op_next         = op_reg;
        acc_next        = acc_reg;
        mq_next         = mq_reg;
        b_next          = b_reg;
        result_next     = result_reg;
        illegal_next    = illegal_reg;
        has_result_next = has_result_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    op_next = ALU_Operation;
                    if (is_multi) begin
                        state_next = CALC;
                        cnt_next   = '0;
                        acc_next   = '0;
                        mq_next    = oprd1;
                        b_next     = oprd2;
                    end else begin
                        state_next      = DONE;
                        result_next     = ss_res;
                        illegal_next    = !ss_legal;
                        has_result_next = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_next = step_acc;
                mq_next  = step_mq;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == SHW'(XLEN - 1)) begin
                    state_next      = DONE;
                    result_next     = calc_res;
                    illegal_next    = 1'b0;
                    has_result_next = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            op_reg         <= '0;
            acc_reg        <= '0;
            mq_reg         <= '0;
            b_reg          <= '0;
            result_reg     <= '0;
            illegal_reg    <= 1'b0;
            has_result_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            op_reg         <= op_next;
            acc_reg        <= acc_next;
            mq_reg         <= mq_next;
            b_reg          <= b_next;
            result_reg     <= result_next;
            illegal_reg    <= illegal_next;
            has_result_reg <= has_result_next;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign result     = result_reg;
    // zero stays low until a result has been produced since reset.
    assign zero       = has_result_reg && (result_reg == '0);
    assign illegal_op = illegal_reg;

endmodule
